// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared state encoding and default widths for the psum accumulator
package psum_pkg;

  localparam int ACC_W_DEFAULT = 40;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_FIN = 2'd1,
    ST_OUT = 2'd2
  } state_t;

endpackage

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - round half up, arithmetic shift, optional relu, saturate to WIDTH
module psum_requant
  import psum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic signed [WIDTH-1:0] data,
  output logic                    sat
);

  // One guard bit so the rounding increment cannot wrap a near-full accumulator.
  localparam logic signed [ACC_W:0] MAX_V =
    $signed({{(ACC_W + 1 - WIDTH){1'b0}}, 1'b0, {(WIDTH - 1){1'b1}}});
  localparam logic signed [ACC_W:0] MIN_V =
    $signed({{(ACC_W + 1 - WIDTH){1'b1}}, 1'b1, {(WIDTH - 1){1'b0}}});

  logic        [ACC_W:0] rnd_add;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shf;
  logic signed [ACC_W:0] clip;

  always_comb begin
    rnd_add = '0;
    if (shift != 5'd0) begin
      rnd_add = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
    end
    rnd = $signed({acc[ACC_W-1], acc} + rnd_add);
    shf = rnd >>> shift;
    if (relu_en && shf[ACC_W]) begin
      shf = '0;
    end
    clip = shf;
    sat  = 1'b0;
    if (shf > MAX_V) begin
      clip = MAX_V;
      sat  = 1'b1;
    end else if (shf < MIN_V) begin
      clip = MIN_V;
      sat  = 1'b1;
    end
    data = clip[WIDTH-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - multi-beat partial-sum accumulator with bias and requantised output
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [2*WIDTH-1:0] in_sum,
  input  logic                      in_last,
  input  logic signed [2*WIDTH-1:0] bias,
  input  logic        [4:0]         shift,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_data,
  output logic                      out_sat,
  output logic        [CNT_W-1:0]   beat_cnt
);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  base;
  logic                     first;
  logic        [4:0]        shift_q;
  logic                     relu_q;
  logic signed [WIDTH-1:0]  rq_data;
  logic                     rq_sat;
  logic                     accept;

  assign sum_ext  = {{(ACC_W - 2*WIDTH){in_sum[2*WIDTH-1]}}, in_sum};
  assign bias_ext = {{(ACC_W - 2*WIDTH){bias[2*WIDTH-1]}}, bias};
  assign base     = first ? bias_ext : acc;
  assign in_ready = (state == ST_ACC) && !rst;
  assign accept   = in_valid && in_ready;

  psum_requant #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_requant (
    .acc     (acc),
    .shift   (shift_q),
    .relu_en (relu_q),
    .data    (rq_data),
    .sat     (rq_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      beat_cnt  <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc      <= base + sum_ext;
            beat_cnt <= first ? CNT_W'(1) : beat_cnt + CNT_W'(1);
            first    <= 1'b0;
            if (in_last) begin
              shift_q <= shift;
              relu_q  <= relu_en;
              state   <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          out_data <= rq_data;
          out_sat  <= rq_sat;
          state    <= ST_OUT;
        end
        ST_OUT: begin
          // Result registers settle one cycle before out_valid is raised.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            first     <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator
module tb_psum_accumulator;

  localparam int WIDTH = 16;
  localparam int ACC_W = 40;
  localparam int CNT_W = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [2*WIDTH-1:0] in_sum;
  logic                      in_last;
  logic signed [2*WIDTH-1:0] bias;
  logic        [4:0]         shift;
  logic                      relu_en;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [WIDTH-1:0]   out_data;
  logic                      out_sat;
  logic        [CNT_W-1:0]   beat_cnt;

  psum_accumulator #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nb;
    int s0;
    int s1;
    int s2;
    int b;
    int sh;
    bit relu;
    int exp_data;
    bit exp_sat;
    int exp_cnt;
  } vec_t;

  typedef struct {
    int data;
    bit sat;
    int cnt;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting posedge.
  task automatic send_beat(input int s, input bit last, input int b, input int sh, input bit r);
    int waited;
    in_valid = 1'b1;
    in_sum   = 32'(s);
    in_last  = last;
    bias     = 32'(b);
    shift    = 5'(sh);
    relu_en  = r;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input int d, input bit s, input int c);
    exp_t e;
    e.data = d;
    e.sat  = s;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Checks the two-edge latency, then pops the scoreboard and handshakes.
  task automatic collect(input string tag);
    exp_t e;
    int   waited;
    check({tag, "_valid_fin"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid_t1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid_t2"}, out_valid, 1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, out_data, e.data);
      check({tag, "_sat"}, out_sat, e.sat);
      check({tag, "_cnt"}, beat_cnt, e.cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s[3];
    s[0] = v.s0;
    s[1] = v.s1;
    s[2] = v.s2;
    for (int k = 0; k < v.nb; k++) begin
      if (k == v.nb - 1) push_exp(v.exp_data, v.exp_sat, v.exp_cnt);
      send_beat(s[k], k == v.nb - 1, v.b, v.sh, v.relu);
    end
    collect(tag);
  endtask

  initial begin
    vecs[0] = '{1, 100, 0, 0, 10, 0, 0, 110, 0, 1};
    vecs[1] = '{3, 1000, -200, 302, 0, 2, 0, 276, 0, 3};
    vecs[2] = '{2, 40000, 40000, 0, 0, 0, 0, 32767, 1, 2};
    vecs[3] = '{2, -40000, -40000, 0, 0, 0, 0, -32768, 1, 2};
    vecs[4] = '{1, -50, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[5] = '{1, -50, 0, 0, 0, 0, 0, -50, 0, 1};
    vecs[6] = '{1, -5, 0, 0, 0, 1, 0, -2, 0, 1};
    vecs[7] = '{1, 24, 0, 0, 0, 4, 0, 2, 0, 1};
    vecs[8] = '{2, -24, 30, 0, -100, 0, 1, 0, 0, 2};
    vecs[9] = '{3, 100000, 100000, 100000, 5, 3, 1, 32767, 1, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_last   = 1'b0;
    bias      = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held, offered beats ignored, in_ready back after handshake.
    push_exp(1234, 0, 1);
    send_beat(1234, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    in_sum   = 32'(999);
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_data_hold", out_data, 1234);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      check("bp_data", out_data, e.data);
      check("bp_cnt", beat_cnt, e.cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    run_vec('{1, 5, 0, 0, 0, 0, 0, 5, 0, 1}, "bp_next");

    // Reset mid-job discards the partial accumulation.
    send_beat(500, 0, 0, 0, 0);
    send_beat(500, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready_back", in_ready, 1);
    check("mid_rst_cnt", beat_cnt, 0);
    @(negedge clk);
    run_vec('{1, 7, 0, 0, 3, 0, 0, 10, 0, 1}, "mid_rst");

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
